// File: rtl/mem_avalon_master.sv
// CPU load/store to Avalon-MM master: one transfer at a time with byte lanes,
// sign/zero extension of loads and misalignment detection before any bus cycle.
module mem_avalon_master (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [2:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic [31:0] avm_address,
  output logic        avm_read,
  output logic        avm_write,
  output logic [3:0]  avm_byteenable,
  output logic [31:0] avm_writedata,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata
);

  localparam logic [2:0] OP_LB  = 3'd0;
  localparam logic [2:0] OP_LBU = 3'd1;
  localparam logic [2:0] OP_LH  = 3'd2;
  localparam logic [2:0] OP_LHU = 3'd3;
  localparam logic [2:0] OP_LW  = 3'd4;
  localparam logic [2:0] OP_SB  = 3'd5;
  localparam logic [2:0] OP_SH  = 3'd6;

  typedef enum logic [1:0] {IDLE = 2'd0, BUS = 2'd1, RESP = 2'd2} state_t;

  state_t      state_reg;
  logic [2:0]  op_reg;
  logic [1:0]  lane_reg;

  logic        is_byte;
  logic        is_half;
  logic        is_store;
  logic        misaligned;
  logic [3:0]  be_next;
  logic [31:0] wd_next;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] load_value;

  // Decode of the request presented in IDLE; only used on the accepting edge.
  always_comb begin
    is_byte    = (op == OP_LB) || (op == OP_LBU) || (op == OP_SB);
    is_half    = (op == OP_LH) || (op == OP_LHU) || (op == OP_SH);
    is_store   = (op > OP_LW);
    misaligned = is_half ? addr[0] : (!is_byte && (addr[1:0] != 2'b00));
    be_next    = 4'b1111;
    wd_next    = wdata;
    if (is_byte) begin
      be_next = 4'b0001 << addr[1:0];
      wd_next = wdata << {addr[1:0], 3'b000};
    end else if (is_half) begin
      be_next = addr[1] ? 4'b1100 : 4'b0011;
      wd_next = addr[1] ? {wdata[15:0], 16'h0000} : {16'h0000, wdata[15:0]};
    end
  end

  // Lane extraction of the returned word for the latched load.
  always_comb begin
    lane_byte  = avm_readdata[{lane_reg, 3'b000} +: 8];
    lane_half  = lane_reg[1] ? avm_readdata[31:16] : avm_readdata[15:0];
    case (op_reg)
      OP_LB:   load_value = {{24{lane_byte[7]}}, lane_byte};
      OP_LBU:  load_value = {24'h000000, lane_byte};
      OP_LH:   load_value = {{16{lane_half[15]}}, lane_half};
      OP_LHU:  load_value = {16'h0000, lane_half};
      default: load_value = avm_readdata;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= IDLE;
      op_reg         <= 3'd0;
      lane_reg       <= 2'd0;
      busy           <= 1'b0;
      done           <= 1'b0;
      err            <= 1'b0;
      rdata          <= 32'h0;
      avm_address    <= 32'h0;
      avm_read       <= 1'b0;
      avm_write      <= 1'b0;
      avm_byteenable <= 4'h0;
      avm_writedata  <= 32'h0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req) begin
            op_reg   <= op;
            lane_reg <= addr[1:0];
            busy     <= 1'b1;
            if (misaligned) begin
              state_reg <= RESP;
              done      <= 1'b1;
              err       <= 1'b1;
            end else begin
              state_reg      <= BUS;
              avm_address    <= {addr[31:2], 2'b00};
              avm_read       <= !is_store;
              avm_write      <= is_store;
              avm_byteenable <= be_next;
              avm_writedata  <= wd_next;
            end
          end
        end
        BUS: begin
          if (!avm_waitrequest) begin
            state_reg <= RESP;
            avm_read  <= 1'b0;
            avm_write <= 1'b0;
            done      <= 1'b1;
            if (op_reg <= OP_LW) rdata <= load_value;
          end
        end
        RESP: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
          done      <= 1'b0;
          err       <= 1'b0;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_avalon_master.sv
// Randomized bench for mem_avalon_master: a waitstate-injecting Avalon slave plus
// a byte-level memory model that predicts enables, lane data and load extension.
module tb_mem_avalon_master;

  localparam logic [31:0] BASE = 32'hBFC00000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        busy, done, err;
  logic [31:0] rdata;
  logic [31:0] avm_address;
  logic        avm_read, avm_write;
  logic [3:0]  avm_byteenable;
  logic [31:0] avm_writedata;
  logic        avm_waitrequest = 1'b0;
  logic [31:0] avm_readdata = 32'h0;

  mem_avalon_master dut (
    .clk(clk), .reset(reset), .req(req), .op(op), .addr(addr), .wdata(wdata),
    .busy(busy), .done(done), .err(err), .rdata(rdata),
    .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
    .avm_byteenable(avm_byteenable), .avm_writedata(avm_writedata),
    .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int wait_target = 0;
  int wait_cnt = 0;
  logic [31:0] smem [16];
  logic [7:0]  rmem [64];
  logic [31:0] ref_rdata = 32'h0;

  typedef struct packed {
    int          lat;
    int          bus;
    logic [31:0] rdata;
    logic        err;
    logic [3:0]  be;
    logic [31:0] adr;
    logic [31:0] wd;
    logic        rd;
    logic        wr;
    logic        stable;
    logic        overlap;
    logic        timeout;
  } obs_t;

  // Slave: stalls wait_target cycles per transfer, then completes. Outside a
  // transfer waitrequest and readdata are noise that the master must ignore.
  always @(negedge clk) begin
    if (avm_read || avm_write) begin
      if (wait_cnt < wait_target) begin
        avm_waitrequest = 1'b1;
        wait_cnt++;
      end else begin
        avm_waitrequest = 1'b0;
        avm_readdata = smem[avm_address[5:2]];
        if (avm_write)
          for (int b = 0; b < 4; b++)
            if (avm_byteenable[b]) smem[avm_address[5:2]][8*b +: 8] = avm_writedata[8*b +: 8];
      end
    end else begin
      wait_cnt = 0;
      avm_waitrequest = 1'($urandom_range(0, 1));
      avm_readdata = $urandom;
    end
  end

  function automatic int f_size(input logic [2:0] o);
    case (o)
      3'd0, 3'd1, 3'd5: return 1;
      3'd2, 3'd3, 3'd6: return 2;
      default:          return 4;
    endcase
  endfunction

  function automatic bit f_mis(input logic [2:0] o, input logic [31:0] a);
    return (int'(a[1:0]) % f_size(o)) != 0;
  endfunction

  function automatic logic [3:0] f_be(input logic [2:0] o, input logic [31:0] a);
    logic [3:0] m;
    m = (f_size(o) == 1) ? 4'b0001 : (f_size(o) == 2) ? 4'b0011 : 4'b1111;
    return m << a[1:0];
  endfunction

  function automatic logic [31:0] f_load(input logic [2:0] o, input logic [31:0] a);
    logic [31:0] v;
    int base_i;
    v = 32'h0;
    base_i = int'(a[5:0]);
    for (int i = 0; i < f_size(o); i++) v[8*i +: 8] = rmem[base_i + i];
    if (o == 3'd0 && v[7])  v = v | 32'hFFFFFF00;
    if (o == 3'd2 && v[15]) v = v | 32'hFFFF0000;
    return v;
  endfunction

  task automatic model_store(input logic [2:0] o, input logic [31:0] a, input logic [31:0] d);
    for (int i = 0; i < f_size(o); i++) rmem[int'(a[5:0]) + i] = d[8*i +: 8];
  endtask

  task automatic run_txn(input logic [2:0] t_op, input logic [31:0] t_addr,
                         input logic [31:0] t_wdata, input int waits, input bit rel,
                         output obs_t o);
    bit seen;
    seen = 1'b0;
    o = '0;
    o.stable = 1'b1;
    @(negedge clk);
    if (rel) reset = 1'b1;
    op = t_op; addr = t_addr; wdata = t_wdata; wait_target = waits; req = 1'b1;
    @(posedge clk);
    #1;
    req = 1'b0; op = 3'($urandom); addr = $urandom; wdata = $urandom;
    for (int n = 0; n < 64 && !seen; n++) begin
      @(negedge clk);
      if (avm_read || avm_write) begin
        if (o.bus == 0) begin
          o.be = avm_byteenable; o.adr = avm_address; o.wd = avm_writedata;
          o.rd = avm_read; o.wr = avm_write;
        end else if ({avm_byteenable, avm_address, avm_writedata, avm_read, avm_write}
                     !== {o.be, o.adr, o.wd, o.rd, o.wr}) begin
          o.stable = 1'b0;
        end
        if (avm_read && avm_write) o.overlap = 1'b1;
        o.bus++;
      end
      if (done) begin
        seen = 1'b1; o.lat = n; o.rdata = rdata; o.err = err;
      end
    end
    o.timeout = !seen;
    $display("txn op=%0d addr=%h wdata=%h waits=%0d lat=%0d err=%b rdata=%h",
             t_op, t_addr, t_wdata, waits, o.lat + 1, o.err, o.rdata);
  endtask

  task automatic test_reset();
    #1 reset = 1'b0;
    #11;
    total++;
    if ({busy, done, err} !== 3'b000) begin
      bad++; $display("FAIL reset_flags got=%b exp=000", {busy, done, err});
    end
    total++;
    if (rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
    total++;
    if ({avm_address, avm_read, avm_write, avm_byteenable, avm_writedata} !== 70'h0) begin
      bad++; $display("FAIL reset_avm got=%h exp=0",
                      {avm_address, avm_read, avm_write, avm_byteenable, avm_writedata});
    end
    @(negedge clk) reset = 1'b1;
  endtask

  task automatic test_fill();
    obs_t o;
    logic [31:0] d;
    for (int k = 0; k < 16; k++) begin
      d = $urandom;
      run_txn(3'd7, BASE + 32'(4 * k), d, $urandom_range(0, 2), 1'b0, o);
      model_store(3'd7, BASE + 32'(4 * k), d);
      total++;
      if (o.timeout || o.err !== 1'b0 || o.wr !== 1'b1) begin
        bad++; $display("FAIL fill_sw got=to%0d/err%b/wr%b exp=to0/err0/wr1", o.timeout, o.err, o.wr);
      end
    end
  endtask

  task automatic test_lw_directed();
    obs_t o;
    run_txn(3'd7, 32'hBFC00004, 32'h89ABCDEF, 0, 1'b0, o);
    model_store(3'd7, 32'hBFC00004, 32'h89ABCDEF);
    run_txn(3'd4, 32'hBFC00004, 32'h0, 0, 1'b0, o);
    ref_rdata = 32'h89ABCDEF;
    total++;
    if (o.adr !== 32'hBFC00004) begin bad++; $display("FAIL lw_addr got=%h exp=bfc00004", o.adr); end
    total++;
    if (o.be !== 4'b1111) begin bad++; $display("FAIL lw_be got=%b exp=1111", o.be); end
    total++;
    if (o.timeout || o.lat + 1 != 2) begin bad++; $display("FAIL lw_latency got=%0d exp=2", o.lat + 1); end
    total++;
    if (o.rdata !== 32'h89ABCDEF) begin bad++; $display("FAIL lw_rdata got=%h exp=89abcdef", o.rdata); end
  endtask

  task automatic test_lb_sign();
    obs_t o;
    run_txn(3'd7, 32'hBFC00004, 32'h80112233, 0, 1'b0, o);
    model_store(3'd7, 32'hBFC00004, 32'h80112233);
    run_txn(3'd0, 32'hBFC00007, 32'h0, 1, 1'b0, o);
    total++;
    if (o.be !== 4'b1000) begin bad++; $display("FAIL lb_be got=%b exp=1000", o.be); end
    total++;
    if (o.rdata !== 32'hFFFFFF80) begin bad++; $display("FAIL lb_rdata got=%h exp=ffffff80", o.rdata); end
    run_txn(3'd1, 32'hBFC00007, 32'h0, 0, 1'b0, o);
    ref_rdata = 32'h00000080;
    total++;
    if (o.rdata !== 32'h00000080) begin bad++; $display("FAIL lbu_rdata got=%h exp=00000080", o.rdata); end
  endtask

  task automatic test_sh_wait();
    obs_t o;
    run_txn(3'd6, 32'hBFC00002, 32'h0000BEEF, 3, 1'b0, o);
    model_store(3'd6, 32'hBFC00002, 32'h0000BEEF);
    total++;
    if (o.wr !== 1'b1 || o.rd !== 1'b0) begin bad++; $display("FAIL sh_dir got=rd%b/wr%b exp=rd0/wr1", o.rd, o.wr); end
    total++;
    if (o.wd[31:16] !== 16'hBEEF || o.be !== 4'b1100) begin
      bad++; $display("FAIL sh_lane got=%h/%b exp=beef/1100", o.wd[31:16], o.be);
    end
    total++;
    if (o.bus != 4 || !o.stable) begin bad++; $display("FAIL sh_hold got=%0d/%b exp=4/1", o.bus, o.stable); end
    total++;
    if (o.timeout || o.lat + 1 != 5) begin bad++; $display("FAIL sh_latency got=%0d exp=5", o.lat + 1); end
    total++;
    if (o.rdata !== ref_rdata) begin bad++; $display("FAIL sh_rdata_hold got=%h exp=%h", o.rdata, ref_rdata); end
  endtask

  task automatic test_misaligned();
    obs_t o;
    run_txn(3'd4, 32'hBFC00006, 32'h0, 0, 1'b0, o);
    total++;
    if (o.bus != 0) begin bad++; $display("FAIL mis_nobus got=%0d exp=0", o.bus); end
    total++;
    if (o.timeout || o.err !== 1'b1) begin bad++; $display("FAIL mis_err got=%b exp=1", o.err); end
    total++;
    if (o.rdata !== ref_rdata) begin bad++; $display("FAIL mis_rdata got=%h exp=%h", o.rdata, ref_rdata); end
  endtask

  task automatic test_random();
    obs_t o;
    logic [2:0]  t_op;
    logic [31:0] a, d, bm, exp_wd;
    int w;
    for (int t = 0; t < 80; t++) begin
      t_op = 3'($urandom);
      a = BASE + 32'($urandom_range(0, 63));
      d = $urandom;
      w = $urandom_range(0, 3);
      run_txn(t_op, a, d, w, 1'b0, o);
      total++;
      if (o.timeout) begin bad++; $display("FAIL rnd_timeout got=none exp=done"); end
      if (f_mis(t_op, a)) begin
        total++;
        if (o.err !== 1'b1 || o.bus != 0 || o.lat != 0) begin
          bad++; $display("FAIL rnd_mis got=err%b/bus%0d/lat%0d exp=err1/bus0/lat0", o.err, o.bus, o.lat);
        end
        total++;
        if (o.rdata !== ref_rdata) begin bad++; $display("FAIL rnd_mis_rdata got=%h exp=%h", o.rdata, ref_rdata); end
      end else begin
        total++;
        if (o.err !== 1'b0 || o.lat != w + 1 || o.bus != w + 1 || !o.stable || o.overlap) begin
          bad++; $display("FAIL rnd_bus got=err%b/lat%0d/bus%0d/st%b/ov%b exp=err0/lat%0d/bus%0d/st1/ov0",
                          o.err, o.lat, o.bus, o.stable, o.overlap, w + 1, w + 1);
        end
        total++;
        if (o.adr !== (a & 32'hFFFFFFFC) || o.be !== f_be(t_op, a)) begin
          bad++; $display("FAIL rnd_addr_be got=%h/%b exp=%h/%b", o.adr, o.be, a & 32'hFFFFFFFC, f_be(t_op, a));
        end
        total++;
        if (o.rd !== (t_op < 3'd5) || o.wr !== (t_op >= 3'd5)) begin
          bad++; $display("FAIL rnd_dir got=rd%b/wr%b exp=rd%b/wr%b", o.rd, o.wr, t_op < 3'd5, t_op >= 3'd5);
        end
        if (t_op >= 3'd5) begin
          for (int b = 0; b < 4; b++) bm[8*b +: 8] = {8{f_be(t_op, a)[b]}};
          exp_wd = (d << {a[1:0], 3'b000}) & bm;
          model_store(t_op, a, d);
          total++;
          if ((o.wd & bm) !== exp_wd) begin bad++; $display("FAIL rnd_wdata got=%h exp=%h", o.wd & bm, exp_wd); end
          total++;
          if (o.rdata !== ref_rdata) begin bad++; $display("FAIL rnd_st_rdata got=%h exp=%h", o.rdata, ref_rdata); end
        end else begin
          ref_rdata = f_load(t_op, a);
          total++;
          if (o.rdata !== ref_rdata) begin bad++; $display("FAIL rnd_load got=%h exp=%h", o.rdata, ref_rdata); end
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, v, got;
    int dones, wlast, rrise, rd_rises;
    logic prev_rd;
    a = BASE + 32'(4 * $urandom_range(0, 15));
    v = $urandom;
    dones = 0; wlast = -1; rrise = -1; rd_rises = 0; prev_rd = 1'b0; got = 32'h0;
    @(negedge clk);
    wait_target = 0; op = 3'd7; addr = a; wdata = v; req = 1'b1;
    for (int n = 0; n < 40 && dones < 2; n++) begin
      @(negedge clk);
      if (avm_write) wlast = n;
      if (avm_read && !prev_rd) begin rd_rises++; if (rrise < 0) rrise = n; end
      prev_rd = avm_read;
      if (busy && !done) wdata = $urandom;
      if (done) begin
        dones++;
        if (dones == 1) op = 3'd4;
        else begin got = rdata; req = 1'b0; end
      end
    end
    model_store(3'd7, a, v);
    ref_rdata = v;
    $display("txn back_to_back addr=%h sw=%h lw=%h gap=%0d", a, v, got, rrise - wlast - 1);
    total++;
    if (dones != 2 || rd_rises != 1) begin bad++; $display("FAIL b2b_count got=%0d/%0d exp=2/1", dones, rd_rises); end
    total++;
    if (wlast < 0 || rrise - wlast - 1 < 2) begin bad++; $display("FAIL b2b_gap got=%0d exp=>=2", rrise - wlast - 1); end
    total++;
    if (got !== v) begin bad++; $display("FAIL b2b_rdata got=%h exp=%h", got, v); end
  endtask

  task automatic test_reset_mid_bus();
    obs_t o;
    logic [31:0] a;
    int spurious;
    spurious = 0;
    @(negedge clk);
    wait_target = 10; op = 3'd4; addr = BASE + 32'h8; req = 1'b1;
    @(posedge clk);
    #1 req = 1'b0;
    @(negedge clk);
    total++;
    if (avm_read !== 1'b1) begin bad++; $display("FAIL rst_setup got=%b exp=1", avm_read); end
    #2 reset = 1'b0;
    #1;
    total++;
    if ({avm_read, busy, done} !== 3'b000) begin
      bad++; $display("FAIL rst_async got=%b exp=000", {avm_read, busy, done});
    end
    total++;
    if (rdata !== 32'h0 || avm_address !== 32'h0) begin
      bad++; $display("FAIL rst_clear got=%h/%h exp=0/0", rdata, avm_address);
    end
    ref_rdata = 32'h0;
    repeat (3) begin
      @(negedge clk);
      if (done || busy || avm_read) spurious++;
    end
    total++;
    if (spurious != 0) begin bad++; $display("FAIL rst_hold got=%0d exp=0", spurious); end
    a = BASE + 32'(4 * $urandom_range(0, 15));
    run_txn(3'd4, a, 32'h0, 0, 1'b1, o);
    ref_rdata = f_load(3'd4, a);
    total++;
    if (o.timeout || o.lat + 1 != 2) begin bad++; $display("FAIL rst_first_req got=%0d exp=2", o.lat + 1); end
    total++;
    if (o.rdata !== ref_rdata) begin bad++; $display("FAIL rst_load got=%h exp=%h", o.rdata, ref_rdata); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_lw_directed();
    test_lb_sign();
    test_sh_wait();
    test_misaligned();
    test_random();
    test_back_to_back();
    test_reset_mid_bus();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_avalon_master.md
MEM_AVALON_MASTER -- requirements
Module: mem_avalon_master

Interface
REQ-001 The block SHALL have no parameters.
REQ-002 The block SHALL use one clock and an asynchronous, active-low reset, with ports named as follows:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
REQ-003 The CPU-side ports SHALL be:
- req  in  1  start pulse; sampled only in IDLE
- op  in  3  0=LB 1=LBU 2=LH 3=LHU 4=LW 5=SB 6=SH 7=SW
- addr  in  32  byte address
- wdata  in  32  store data; low byte/half/word used
- busy  out  1  transaction in progress
- done  out  1  one-cycle completion pulse
- err  out  1  misalignment flag, valid with done
- rdata  out  32  extended load result
REQ-004 The Avalon-side ports SHALL be:
- avm_address  out  32  word-aligned address
- avm_read  out  1  read request
- avm_write  out  1  write request
- avm_byteenable  out  4  bit i enables bits 8i+7:8i
- avm_writedata  out  32  lane-shifted store data
- avm_waitrequest  in  1  slave stall
- avm_readdata  in  32  read data

Function
REQ-005 The FSM SHALL have three states: IDLE, BUS and RESP.
- IDLE -> BUS on req with an aligned access.
- IDLE -> RESP on req with a misaligned access.
- BUS -> RESP at the first clk edge where avm_waitrequest=0.
- RESP -> IDLE unconditionally.
REQ-006 In IDLE, on req=1, the block SHALL latch op, addr and wdata; req SHALL be ignored in BUS and RESP.
REQ-007 An access SHALL be misaligned when LH/LHU/SH have addr[0]=1, or LW/SW have addr[1:0]!=0; LB/LBU/SB are never misaligned.
REQ-008 A misaligned access SHALL issue no bus cycle and SHALL go to RESP with err=1 and rdata unchanged.
REQ-009 The Avalon outputs SHALL be driven only from registers and SHALL be held stable throughout BUS:
- avm_address = {addr[31:2],2'b00}
- avm_read = 1 for loads; avm_write = 1 for stores
REQ-010 avm_byteenable SHALL be:
- byte ops: 1<<addr[1:0]
- half ops: addr[1]=0 -> 4'b0011, addr[1]=1 -> 4'b1100
- word ops: 4'b1111
- loads use the same enables as stores.
REQ-011 avm_writedata SHALL be wdata shifted left by 8*addr[1:0] for SB, by 16*addr[1] for SH, and unshifted for SW.
REQ-012 On BUS completion of a load, rdata SHALL be loaded from avm_readdata as follows:
- select the lane given by addr
- LB/LH sign-extend to 32 bits; LBU/LHU zero-extend
- LW passes through unchanged
REQ-013 rdata SHALL hold its value until the next successful load.
REQ-014 avm_read and avm_write SHALL deassert on leaving BUS and SHALL stay low in RESP and IDLE, so every transfer is separated by at least two low cycles; the slave detects requests on rising edges of read/write.
REQ-015 avm_read and avm_write SHALL never be high simultaneously.
REQ-016 done SHALL be high exactly during the RESP cycle; err SHALL be high only in that cycle.
REQ-017 busy SHALL be high in BUS and RESP and low in IDLE.
REQ-018 Latency: with avm_waitrequest held at 0, done SHALL occur 2 cycles after req is sampled; each cycle of waitrequest=1 in BUS SHALL add one cycle.
REQ-019 avm_waitrequest SHALL be ignored outside BUS.

Reset
REQ-020 While reset=0, asynchronously, the state SHALL be IDLE and all outputs SHALL be 0 (including rdata and avm_*).
REQ-021 A reset during BUS SHALL abandon the transfer immediately: avm_read/avm_write drop without completion and no done is issued.
REQ-022 After reset deasserts, the first accepted req SHALL be sampled on the first clk edge with reset=1.

Verification
REQ-023 LW, addr=0xBFC00004, readdata=0x89ABCDEF, waitrequest=0 -> avm_address=0xBFC00004, byteenable=1111, done 2 cycles after req, rdata=0x89ABCDEF.
REQ-024 LB, addr=0xBFC00007, readdata=0x80112233 -> byteenable=1000, rdata=0xFFFFFF80; same access with LBU -> rdata=0x00000080.
REQ-025 SH, addr=0xBFC00002, wdata=0x0000BEEF, waitrequest high for 3 cycles -> avm_write, avm_writedata[31:16]=0xBEEF and byteenable=1100 all held stable 4 cycles, done 5 cycles after req.
REQ-026 LW, addr=0xBFC00006 -> no avm_read ever asserted, done=1 and err=1 in the same cycle, rdata unchanged.
REQ-027 Back-to-back SW then LW to the same address, with req held high continuously -> avm_write low for at least 2 cycles before avm_read rises, and LW returns the stored word; req is ignored while busy=1.
REQ-028 reset=0 asserted mid-BUS with waitrequest=1 -> avm_read=0, busy=0, done=0 immediately, with no clk edge required.
